word_uart_tx: RTL and testbench
===============================

// Module: word_uart_tx
// PURPOSE
//   Serialises the processor's DATA_LENGTH-bit result word (o_Data/flag of full_top) onto an 8N1 UART line.
//   Sits directly downstream of the CPU: a 0->1 transition on the halt flag launches one transfer.
//   The word is sent as DATA_LENGTH/8 bytes, LSB byte first.
//   Includes its own bit-period timer; no external baud tick is required.
// PARAMETERS
//   DATA_LENGTH   16    width of the result word; must be a multiple of 8 (elaboration error otherwise)
//   NB_BYTE       8     data bits per UART frame
//   CLKS_PER_BIT  5208  i_clock cycles per UART bit (50 MHz / 9600 baud); minimum 2
// PORTS
//   i_clock    in   1            system clock, rising edge
//   i_reset    in   1            synchronous, active-low reset
//   i_start    in   1            level input (CPU halt flag); a transfer launches on its 0->1 edge only
//   i_data     in   DATA_LENGTH  word to send; sampled in the edge-detect cycle
//   o_tx       out  1            UART line; idles high
//   o_busy     out  1            high from launch until the last stop bit ends
//   o_tx_done  out  1            one-cycle pulse when the full word has been sent
// BEHAVIOUR
//   Reset (i_reset==0 at an edge):
//     - State IDLE; o_tx=1, o_busy=0, o_tx_done=0.
//     - Shift register, bit counter, byte counter and timer cleared; start-edge register cleared to 0.
//     - If i_start is already high when reset releases, exactly one transfer is launched.
//   Launch: in IDLE, cycle N sees i_start==1 and prev==0 -> i_data latched.
//     - From cycle N+1: o_tx=0 (start bit) and o_busy=1.
//   States:
//     - IDLE -> START on edge.
//     - START: CLKS_PER_BIT cycles at 0 -> DATA.
//     - DATA: NB_BYTE bits, LSB first, CLKS_PER_BIT cycles each -> STOP.
//     - STOP: CLKS_PER_BIT cycles at 1. If bytes remain: -> START (shift next byte in, no idle gap); else -> DONE.
//     - DONE: 1 cycle, o_tx_done=1, o_tx=1, o_busy=0 -> IDLE.
//   Timing:
//     - A word occupies exactly (DATA_LENGTH/8)*(NB_BYTE+2)*CLKS_PER_BIT cycles of line activity.
//     - o_tx_done asserts in the cycle after the last stop-bit cycle.
//     - A new edge is accepted at the earliest in the cycle after DONE.
//   Edges while busy: ignored. The edge register tracks i_start continuously, so an edge seen during a
//     transfer is lost, and a level still held high after DONE does not relaunch.
//   i_data changes after launch: no effect on the frame in flight.
//   Reset mid-frame: line returns to 1 at the next edge; no o_tx_done pulse; partial frame abandoned.
//   Counter widths:
//     - Timer: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, then wraps to 0 with a bit-end strobe.
//     - Bit counter: $clog2(NB_BYTE+1) bits.
//     - Byte counter: $clog2(DATA_LENGTH/8+1) bits.
//   o_tx, o_busy and o_tx_done are driven from registers; no combinational path from any input.
// STRUCTURE
//   Shared package/header:
//     - State encodings (IDLE, START, DATA, STOP, DONE; 3-bit localparams).
//     - UART frame constants (start=0, stop=1, idle=1).
//     - clog2 helper.
//   Sub-module uart_bit_timer:
//     - Ports: i_clock, i_reset, i_run.
//     - Output o_bit_end: 1-cycle strobe every CLKS_PER_BIT cycles while i_run is high; counter held at 0 while i_run is low.
//   Top level: edge detector, FSM, shift register, bit and byte counters.
// TESTING (CLKS_PER_BIT=4 unless noted)
//   - Basic word: reset low 2 cycles; i_start 0->1 with i_data=16'hA53C.
//     -> line 0 | 0,0,1,1,1,1,0,0 | 1 | 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles.
//     -> o_tx_done pulses at cycle 81 after launch; o_busy high 80 cycles.
//   - Held level: i_start held high 300 cycles -> exactly one transfer and one o_tx_done.
//     -> Then drop for 1 cycle and raise -> second transfer.
//   - Edge while busy: toggle i_start 0->1->0->1 during byte 0 -> no second transfer, o_tx stays on frame.
//   - Reset mid-frame: assert i_reset low during DATA bit 3 of byte 1.
//     -> o_tx=1, o_busy=0 next cycle; no o_tx_done.
//     -> Re-launch with 16'h00FF sends 0xFF then 0x00 correctly.
//   - Data change: change i_data every cycle after launch -> transmitted bytes equal the value sampled at launch.
//   - Param sweep: CLKS_PER_BIT=2 and DATA_LENGTH=32 with 32'h12345678.
//     -> bytes 78,56,34,12 in order; total 80 cycles.

Source files
------------

// File: rtl/word_uart_tx_pkg.sv
// Shared definitions for the word-wide 8N1 UART transmitter: state encoding,
// line levels and a constant log2 helper used to size counters.
package word_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } tx_state_t;

  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE       = 1'b1;

  // Ceiling log2, never narrower than one bit so degenerate counters stay legal.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/word_uart_tx_bit_timer.sv
// Bit-period timer: strobes o_bit_end on the last cycle of every CLKS_PER_BIT
// cycle window while i_run is high; held at zero otherwise.
module uart_bit_timer
  import word_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_run,
  output logic o_bit_end
);

  localparam int TW = clog2(CLKS_PER_BIT);

  logic [TW-1:0] count;
  logic          at_end;

  assign at_end    = (count == TW'(CLKS_PER_BIT - 1));
  assign o_bit_end = i_run && at_end;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      count <= '0;
    end else if (!i_run || at_end) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/word_uart_tx.sv
// Sends a DATA_LENGTH-bit word as DATA_LENGTH/8 8N1 frames, LSB byte first,
// launched by a rising edge on i_start.
//   state | meaning
//   IDLE  | line high, waiting for a 0->1 edge on i_start
//   START | start bit (0) for one bit period
//   DATA  | NB_BYTE data bits, LSB first
//   STOP  | stop bit (1); loops to START while bytes remain
//   DONE  | single cycle, o_tx_done pulse
module word_uart_tx
  import word_uart_tx_pkg::*;
#(
  parameter int DATA_LENGTH  = 16,
  parameter int NB_BYTE      = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [DATA_LENGTH-1:0] i_data,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_tx_done
);

  localparam int NUM_BYTES = DATA_LENGTH / 8;
  localparam int BIT_W     = clog2(NB_BYTE + 1);
  localparam int BYTE_W    = clog2(NUM_BYTES + 1);

  generate
    if ((DATA_LENGTH % 8) != 0) begin : g_bad_length
      $error("word_uart_tx: DATA_LENGTH must be a multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("word_uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  tx_state_t              state, state_nxt;
  logic                   start_prev;
  logic [DATA_LENGTH-1:0] shift_q, shift_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_nxt;
  logic [BYTE_W-1:0]      byte_cnt, byte_nxt;
  logic                   tx_nxt, busy_nxt, done_nxt;
  logic                   timer_run, bit_end;

  assign timer_run = (state == START) || (state == DATA) || (state == STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_run    (timer_run),
    .o_bit_end(bit_end)
  );

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    case (state)
      IDLE: begin
        if (i_start && !start_prev) begin
          state_nxt = START;
          shift_nxt = i_data;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        // Shifting every data bit leaves the next byte's LSB at bit 0 after the stop bit.
        if (bit_end) begin
          shift_nxt = shift_q >> 1;
          if (bit_cnt == BIT_W'(NB_BYTE - 1)) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_cnt == BYTE_W'(NUM_BYTES - 1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = START;
            byte_nxt  = byte_cnt + BYTE_W'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are precomputed from the next state so they can be registered.
    case (state_nxt)
      START:   tx_nxt = FRAME_START_BIT;
      DATA:    tx_nxt = shift_nxt[0];
      STOP:    tx_nxt = FRAME_STOP_BIT;
      default: tx_nxt = LINE_IDLE;
    endcase
    busy_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      o_tx       <= LINE_IDLE;
      o_busy     <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= i_start;
      shift_q    <= shift_nxt;
      bit_cnt    <= bit_nxt;
      byte_cnt   <= byte_nxt;
      o_tx       <= tx_nxt;
      o_busy     <= busy_nxt;
      o_tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Self-checking bench for word_uart_tx: per-cycle line/busy/done checks against
// a frame model computed from bit positions.
module tb_word_uart_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [15:0] data;
  logic        tx, busy, done;

  logic        rst2, start2;
  logic [31:0] data2;
  logic        tx2, busy2, done2;

  int n_cmp  = 0;
  int n_fail = 0;

  word_uart_tx #(.DATA_LENGTH(16), .NB_BYTE(8), .CLKS_PER_BIT(4)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_data(data),
    .o_tx(tx), .o_busy(busy), .o_tx_done(done)
  );

  word_uart_tx #(.DATA_LENGTH(32), .NB_BYTE(8), .CLKS_PER_BIT(2)) dut32 (
    .i_clock(clk), .i_reset(rst2), .i_start(start2), .i_data(data2),
    .o_tx(tx2), .o_busy(busy2), .o_tx_done(done2)
  );

  // Expected {tx, busy, done} k cycles after the launch edge.
  function automatic logic [2:0] exp_obs(input logic [31:0] w, input int nbytes,
                                         input int cpb, input int k);
    int   total, idx, b, p;
    logic bitv;
    total = nbytes * 10 * cpb;
    if (k >= 1 && k <= total) begin
      idx = (k - 1) / cpb;
      b   = idx / 10;
      p   = idx % 10;
      if (p == 0)      bitv = 1'b0;
      else if (p == 9) bitv = 1'b1;
      else             bitv = w[b*8 + p - 1];
      return {bitv, 2'b10};
    end else if (k == total + 1) begin
      return 3'b101;
    end
    return 3'b100;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rst2 = 1'b0; start = 1'b0; start2 = 1'b0; data = '0; data2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset16 got %b expected 100", {tx, busy, done});
    end
    n_cmp++;
    if ({tx2, busy2, done2} !== 3'b100) begin
      n_fail++; $display("FAIL reset32 got %b expected 100", {tx2, busy2, done2});
    end
    rst_n = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release got %b expected 100", {tx, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [2:0] e;
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    start = 1'b0; @(negedge clk);
    data = 16'hA53C; start = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      e = exp_obs({16'h0, 16'hA53C}, 2, 4, k);
      busy_cnt += busy; done_cnt += done;
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL basic k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    n_cmp++;
    if (busy_cnt != 80) begin
      n_fail++; $display("FAIL basic_busy_len got %0d expected 80", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL basic_done_count got %0d expected 1", done_cnt);
    end
    start = 1'b0;
  endtask

  task automatic test_random_words();
    logic [15:0] w;
    logic [2:0]  e;
    for (int n = 0; n < 5; n++) begin
      start = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      w = 16'($urandom); data = w; start = 1'b1;
      for (int k = 1; k <= 83; k++) begin
        @(negedge clk);
        if (k == 1) start = 1'b0;
        e = exp_obs({16'h0, w}, 2, 4, k);
        n_cmp++;
        if ({tx, busy, done} !== e) begin
          n_fail++; $display("FAIL random w=%h k=%0d got %b expected %b", w, k, {tx, busy, done}, e);
        end
      end
    end
  endtask

  task automatic test_held_level();
    logic [15:0] w;
    logic [2:0]  e;
    int done_cnt;
    done_cnt = 0;
    start = 1'b0; @(negedge clk);
    w = 16'($urandom); data = w; start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      done_cnt += done;
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL held k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL held_done_count got %0d expected 1", done_cnt);
    end
    start = 1'b0; @(negedge clk);
    w = 16'($urandom); data = w; start = 1'b1;
    for (int k = 1; k <= 83; k++) begin
      @(negedge clk);
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL held_relaunch k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_edge_while_busy();
    logic [15:0] w;
    logic [2:0]  e;
    start = 1'b0; @(negedge clk);
    w = 16'($urandom); data = w; start = 1'b1;
    for (int k = 1; k <= 122; k++) begin
      @(negedge clk);
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL busy_edge k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
      if (k == 6 || k == 10) start = 1'b0;
      if (k == 8 || k == 12) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w;
    logic [2:0]  e;
    start = 1'b0; @(negedge clk);
    w = 16'($urandom); data = w; start = 1'b1;
    for (int k = 1; k <= 57; k++) begin
      @(negedge clk);
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL pre_reset k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    rst_n = 1'b0; start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      n_cmp++;
      if ({tx, busy, done} !== 3'b100) begin
        n_fail++; $display("FAIL mid_reset c=%0d got %b expected 100", k, {tx, busy, done});
      end
    end
    data = 16'h00FF; start = 1'b1;
    for (int k = 1; k <= 83; k++) begin
      @(negedge clk);
      e = exp_obs(32'h0000_00FF, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL relaunch_00ff k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_with_start_high();
    logic [15:0] w;
    logic [2:0]  e;
    int done_cnt;
    done_cnt = 0;
    w = 16'($urandom); data = w;
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      done_cnt += done;
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL start_at_reset k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL start_at_reset_done got %0d expected 1", done_cnt);
    end
    start = 1'b0;
  endtask

  task automatic test_data_change();
    logic [15:0] w;
    logic [2:0]  e;
    start = 1'b0; @(negedge clk);
    w = 16'($urandom); data = w; start = 1'b1;
    for (int k = 1; k <= 83; k++) begin
      @(negedge clk);
      e = exp_obs({16'h0, w}, 2, 4, k);
      n_cmp++;
      if ({tx, busy, done} !== e) begin
        n_fail++; $display("FAIL data_change k=%0d got %b expected %b", k, {tx, busy, done}, e);
      end
      data = 16'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic [2:0] e;
    int busy_cnt;
    busy_cnt = 0;
    start2 = 1'b0; @(negedge clk);
    data2 = 32'h1234_5678; start2 = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      busy_cnt += busy2;
      e = exp_obs(32'h1234_5678, 4, 2, k);
      n_cmp++;
      if ({tx2, busy2, done2} !== e) begin
        n_fail++; $display("FAIL sweep32 k=%0d got %b expected %b", k, {tx2, busy2, done2}, e);
      end
    end
    n_cmp++;
    if (busy_cnt != 80) begin
      n_fail++; $display("FAIL sweep32_busy_len got %0d expected 80", busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_words();
    test_held_level();
    test_edge_while_busy();
    test_reset_mid_frame();
    test_reset_with_start_high();
    test_data_change();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
